// File: rtl/adc_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_result_buffer_if
// Purpose  : Groups the conversion-side and consumer-side signals of the ADC
//            result buffer into one bundle.
// Signals  : conv_finished, result, dec_ctrl, clear -> into the buffer
//            out_ready                              -> into the buffer
//            out_data, out_valid, fill_level,
//            overflow                               <- from the buffer
// Modports : slave  - the buffer itself
//            master - whatever drives conversions and consumes words
// Revision : 1.0 - initial release
// ============================================================================
interface adc_result_buffer_if #(
  parameter int DATA_BITS  = 12,
  parameter int FIFO_DEPTH = 4
);
  localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

  logic                 conv_finished;
  logic [DATA_BITS-1:0] result;
  logic [1:0]           dec_ctrl;
  logic                 clear;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [FILL_W-1:0]    fill_level;
  logic                 overflow;

  modport slave (
    input  conv_finished, result, dec_ctrl, clear, out_ready,
    output out_data, out_valid, fill_level, overflow
  );

  modport master (
    output conv_finished, result, dec_ctrl, clear, out_ready,
    input  out_data, out_valid, fill_level, overflow
  );
endinterface
`default_nettype wire

// File: rtl/adc_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : adc_result_buffer
// Purpose  : Captures SAR conversion results on the rising edge of
//            conv_finished, averages 1/2/4/8 of them (dec_ctrl) and queues
//            the averaged words in a small FIFO for a ready/valid consumer.
// Ports    : clk  - clock, rising edge
//            nrst - asynchronous active-low reset
//            bus  - adc_result_buffer_if.slave (conversion inputs, clear,
//                   FIFO head word / valid / ready, fill level, overflow)
// Revision : 1.0 - initial release
// ============================================================================
module adc_result_buffer #(
  parameter int DATA_BITS  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                nrst,
  adc_result_buffer_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACC_W = DATA_BITS + 3;   // eight full-scale codes fit

  logic                 conv_d_q,   conv_d_d;
  logic [ACC_W-1:0]     acc_q,      acc_d;
  logic [2:0]           win_cnt_q,  win_cnt_d;
  logic [1:0]           dec_act_q,  dec_act_d;
  logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]     fill_q,     fill_d;
  logic                 ovf_q,      ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

  logic                 cap;
  logic [1:0]           dec_eff;
  logic [2:0]           last_cnt;
  logic                 win_last;
  logic [ACC_W-1:0]     sum;
  logic [DATA_BITS-1:0] word;
  logic                 complete;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;

  always_comb begin
    cap = bus.conv_finished & ~conv_d_q;

    // A fresh window samples dec_ctrl; an open window keeps its own setting.
    dec_eff = (win_cnt_q == 3'd0) ? bus.dec_ctrl : dec_act_q;

    case (dec_eff)
      2'd0:    last_cnt = 3'd0;
      2'd1:    last_cnt = 3'd1;
      2'd2:    last_cnt = 3'd3;
      default: last_cnt = 3'd7;
    endcase

    win_last = (win_cnt_q == last_cnt);
    sum      = acc_q + {3'b000, bus.result};
    word     = DATA_BITS'(sum >> dec_eff);
    complete = cap & win_last;

    empty = (fill_q == CNT_W'(0));
    full  = (fill_q == CNT_W'(FIFO_DEPTH));
    pop   = ~empty & bus.out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push  = complete & (~full | pop);
    drop  = complete & full & ~pop;
  end

  always_comb begin
    conv_d_d  = bus.conv_finished;
    acc_d     = acc_q;
    win_cnt_d = win_cnt_q;
    dec_act_d = dec_act_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    ovf_d     = ovf_q;
    mem_d     = mem_q;

    if (bus.clear) begin
      // dec_act_q is left alone: the zeroed counter forces a reload anyway.
      acc_d     = '0;
      win_cnt_d = 3'd0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      fill_d    = '0;
      ovf_d     = 1'b0;
    end else begin
      if (cap) begin
        dec_act_d = dec_eff;
        if (win_last) begin
          acc_d     = '0;
          win_cnt_d = 3'd0;
        end else begin
          acc_d     = sum;
          win_cnt_d = win_cnt_q + 3'd1;
        end
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      if (push) begin
        mem_d[wr_ptr_q] = word;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
        2'b10:   fill_d = fill_q + CNT_W'(1);
        2'b01:   fill_d = fill_q - CNT_W'(1);
        default: fill_d = fill_q;
      endcase

      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      conv_d_q  <= 1'b1;   // a level already high at release is not an edge
      acc_q     <= '0;
      win_cnt_q <= 3'd0;
      dec_act_q <= 2'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      conv_d_q  <= conv_d_d;
      acc_q     <= acc_d;
      win_cnt_q <= win_cnt_d;
      dec_act_q <= dec_act_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
    end
  end

  assign bus.out_valid  = ~empty;
  assign bus.out_data   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.fill_level = fill_q;
  assign bus.overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_result_buffer
// Purpose  : Self-checking bench for adc_result_buffer. Averaging windows come
//            from a vector table; FIFO full/overflow, clear and reset cases
//            are driven as hand-written sequences. Expected words go into a
//            scoreboard queue and are compared as the consumer takes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_result_buffer;
  localparam int DATA_BITS  = 12;
  localparam int FIFO_DEPTH = 4;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  always #5 clk = ~clk;

  adc_result_buffer_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  adc_result_buffer #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DATA_BITS-1:0] exp_q [$];

  typedef struct packed {
    logic [1:0]                dec;
    logic [3:0]                n;
    logic [7:0][DATA_BITS-1:0] res;
    logic [DATA_BITS-1:0]      exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer side: a word leaves on the next rising edge whenever valid and
  // ready are both high here; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (nrst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none at %0t", bus.out_data, $time);
      end else begin
        chk("out_word", {20'd0, bus.out_data}, {20'd0, exp_q.pop_front()});
      end
    end
  end

  // One conversion: low for a cycle, then high with the new code. Returns
  // just after the edge that captured it.
  task automatic do_conv(input logic [DATA_BITS-1:0] v);
    bus.conv_finished = 1'b0;
    @(posedge clk); #2;
    bus.conv_finished = 1'b1;
    bus.result        = v;
    @(posedge clk); #2;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    exp_q.delete();
    @(posedge clk); #2;
    bus.clear = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #2;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.conv_finished = 1'b0;
    bus.result        = '0;
    bus.dec_ctrl      = 2'd0;
    bus.clear         = 1'b0;
    bus.out_ready     = 1'b1;

    for (int i = 0; i < 7; i++) vecs[i] = '0;
    vecs[0].dec = 2'd0; vecs[0].n = 4'd1; vecs[0].res[0] = 12'h123; vecs[0].exp = 12'h123;
    vecs[1].dec = 2'd0; vecs[1].n = 4'd1; vecs[1].res[0] = 12'hABC; vecs[1].exp = 12'hABC;
    vecs[2].dec = 2'd2; vecs[2].n = 4'd4; vecs[2].exp = 12'd11;
    vecs[2].res[0] = 12'd10; vecs[2].res[1] = 12'd11; vecs[2].res[2] = 12'd12; vecs[2].res[3] = 12'd14;
    vecs[3].dec = 2'd1; vecs[3].n = 4'd2; vecs[3].res[0] = 12'h001; vecs[3].res[1] = 12'h002; vecs[3].exp = 12'h001;
    vecs[4].dec = 2'd1; vecs[4].n = 4'd2; vecs[4].res[0] = 12'hFFF; vecs[4].res[1] = 12'hFFF; vecs[4].exp = 12'hFFF;
    vecs[5].dec = 2'd3; vecs[5].n = 4'd8; vecs[5].exp = 12'd4;
    for (int k = 0; k < 8; k++) vecs[5].res[k] = 12'(k + 1);
    vecs[6].dec = 2'd2; vecs[6].n = 4'd4; vecs[6].res[0] = 12'hFFF; vecs[6].exp = 12'h3FF;

    #1;
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_out_data",   bus.out_data,   0);
    chk("rst_fill_level", bus.fill_level, 0);
    chk("rst_overflow",   bus.overflow,   0);
    @(posedge clk); @(posedge clk); #2;
    nrst = 1'b1;
    @(posedge clk); #2;

    // Averaging windows from the table, consumer always ready.
    for (int v = 0; v < 7; v++) begin
      bus.dec_ctrl = vecs[v].dec;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        if (k == int'(vecs[v].n) - 1) exp_q.push_back(vecs[v].exp);
        do_conv(vecs[v].res[k]);
        if (k < int'(vecs[v].n) - 1) begin
          chk("no_early_push", {bus.out_valid, bus.fill_level}, 0);
        end else begin
          chk("valid_latency", bus.out_valid, 1);
          chk("head_word", bus.out_data, vecs[v].exp);
        end
      end
      wait_drain();
    end

    // Eight full-scale codes; dec_ctrl dropped to 0 mid-window.
    bus.dec_ctrl = 2'd3;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) exp_q.push_back(12'hFFF);
      do_conv(12'hFFF);
      if (k == 2) bus.dec_ctrl = 2'd0;
      if (k < 7) chk("dec8_no_push", bus.fill_level, 0);
    end
    chk("dec8_valid", bus.out_valid, 1);
    wait_drain();

    // Fill the FIFO with the consumer stalled, overflow on the fifth word.
    bus.dec_ctrl  = 2'd0;
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(12'(k * 12'h111));
      do_conv(12'(k * 12'h111));
      if (k == 4) begin
        chk("full_fill",    bus.fill_level, 4);
        chk("full_no_ovf",  bus.overflow,   0);
      end
    end
    chk("ovf_fill",  bus.fill_level, 4);
    chk("ovf_set",   bus.overflow,   1);
    bus.out_ready = 1'b1;
    wait_drain();
    chk("ovf_sticky",   bus.overflow,   1);
    chk("drained_fill", bus.fill_level, 0);
    do_clear();
    chk("clear_ovf", bus.overflow, 0);

    // Full FIFO: completing capture and pop in the same cycle.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(12'(12'h200 + k));
      do_conv(12'(12'h200 + k));
    end
    chk("pp_full", bus.fill_level, 4);
    bus.conv_finished = 1'b0;
    @(posedge clk); #2;
    bus.conv_finished = 1'b1;
    bus.result        = 12'h2AA;
    bus.out_ready     = 1'b1;
    exp_q.push_back(12'h2AA);
    @(posedge clk); #2;
    chk("pp_fill", bus.fill_level, 4);
    chk("pp_ovf",  bus.overflow,   0);
    wait_drain();

    // Clear flushes a partial window and queued data.
    bus.dec_ctrl = 2'd2;
    do_conv(12'd100);
    do_conv(12'd100);
    bus.out_ready = 1'b0;
    bus.dec_ctrl  = 2'd0;
    do_clear();
    chk("clr_fill", bus.fill_level, 0);
    exp_q.push_back(12'd7);
    do_conv(12'd7);
    chk("clr_new_word", bus.out_data, 7);
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset with two words queued, a partial window and conv_finished high.
    bus.out_ready = 1'b0;
    exp_q.push_back(12'h0A1);
    do_conv(12'h0A1);
    exp_q.push_back(12'h0A2);
    do_conv(12'h0A2);
    chk("pre_rst_fill", bus.fill_level, 2);
    bus.dec_ctrl = 2'd1;
    do_conv(12'h0F0);
    nrst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_out_valid",  bus.out_valid,  0);
    chk("arst_out_data",   bus.out_data,   0);
    chk("arst_fill_level", bus.fill_level, 0);
    chk("arst_overflow",   bus.overflow,   0);
    @(posedge clk); @(posedge clk); #2;
    nrst          = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
    end
    chk("post_rst_no_cap", {bus.out_valid, bus.fill_level}, 0);
    bus.dec_ctrl = 2'd0;
    exp_q.push_back(12'h055);
    do_conv(12'h055);
    chk("post_rst_word", bus.out_data, 12'h055);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
